// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decodes opcode/funct into an ALU op and registers the operands.
// Optional operand forwarding from EX/MEM is enabled with `define FORWARDING_EN.
module alu_issue_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        opcode,
    input  logic [5:0]        funct,
    input  logic [REG_W-1:0]  rs_idx,
    input  logic [REG_W-1:0]  rt_idx,
    input  logic [REG_W-1:0]  rd_idx,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic [15:0]       imm16,
    input  logic [4:0]        shamt_in,
    input  logic              flush,
    input  logic              fwd_ex_valid,
    input  logic              fwd_mem_valid,
    input  logic [REG_W-1:0]  fwd_ex_idx,
    input  logic [REG_W-1:0]  fwd_mem_idx,
    input  logic [DATA_W-1:0] fwd_ex_data,
    input  logic [DATA_W-1:0] fwd_mem_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_op,
    output logic              alu_cn,
    output logic [3:0]        alu_shamt,
    output logic [REG_W-1:0]  wb_idx,
    output logic              wb_en,
    output logic              illegal
);

    typedef enum logic [1:0] {
        B_RT   = 2'd0,
        B_RS   = 2'd1,
        B_SEXT = 2'd2,
        B_ZEXT = 2'd3
    } bsel_e;

    logic              r_valid;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [3:0]        r_op;
    logic              r_cn;
    logic [3:0]        r_shamt;
    logic [REG_W-1:0]  r_wb_idx;
    logic              r_wb_en;
    logic              r_ill;

    logic              w_load;
    logic              w_rtype;
    logic [3:0]        w_op;
    bsel_e             w_bsel;
    logic [REG_W-1:0]  w_wb_idx;
    logic              w_wb_en;
    logic              w_ill;
    logic [DATA_W-1:0] w_rs_val;
    logic [DATA_W-1:0] w_rt_val;
    logic [DATA_W-1:0] w_b;

    assign in_ready = !r_valid || out_ready;
    assign w_load   = in_valid && in_ready;
    assign w_rtype  = (opcode == 6'b000000);

    always_comb begin
        w_op     = 4'b0000;
        w_bsel   = B_RT;
        w_wb_idx = rt_idx;
        w_wb_en  = 1'b1;
        w_ill    = 1'b0;
        unique case (1'b1)
            w_rtype: begin
                w_wb_idx = rd_idx;
                case (funct)
                    6'b100000, 6'b100001: w_op = 4'b0001;
                    6'b100010, 6'b100011: w_op = 4'b0010;
                    6'b011000: w_op = 4'b0011;
                    6'b011010: w_op = 4'b0100;
                    6'b100100: w_op = 4'b0101;
                    6'b100101: w_op = 4'b0110;
                    6'b100111: w_op = 4'b0111;
                    6'b100110: w_op = 4'b1000;
                    6'b101000: w_op = 4'b1001;
                    6'b101001: w_op = 4'b1010;
                    6'b001000: begin
                        w_op    = 4'b1011;
                        w_bsel  = B_RS;
                        w_wb_en = 1'b0;
                    end
                    default: begin
                        w_wb_en = 1'b0;
                        w_ill   = 1'b1;
                    end
                endcase
            end
            (opcode == 6'b001000), (opcode == 6'b001001),
            (opcode == 6'b100011): begin
                w_op   = 4'b0001;
                w_bsel = B_SEXT;
            end
            (opcode == 6'b101011): begin
                w_op    = 4'b0001;
                w_bsel  = B_SEXT;
                w_wb_en = 1'b0;
            end
            (opcode == 6'b001100): begin
                w_op   = 4'b0101;
                w_bsel = B_ZEXT;
            end
            (opcode == 6'b001101): begin
                w_op   = 4'b0110;
                w_bsel = B_ZEXT;
            end
            (opcode == 6'b001110): begin
                w_op   = 4'b1000;
                w_bsel = B_ZEXT;
            end
            (opcode == 6'b000100): begin
                w_op    = 4'b0010;
                w_wb_en = 1'b0;
            end
            default: begin
                w_wb_en = 1'b0;
                w_ill   = 1'b1;
            end
        endcase
        if (w_wb_idx == '0) w_wb_en = 1'b0;
    end

`ifdef FORWARDING_EN
    // EX wins over MEM; register 0 is hardwired and never forwarded
    always_comb begin
        w_rs_val = rs_data;
        if (rs_idx != '0 && fwd_ex_valid && fwd_ex_idx == rs_idx)
            w_rs_val = fwd_ex_data;
        else if (rs_idx != '0 && fwd_mem_valid && fwd_mem_idx == rs_idx)
            w_rs_val = fwd_mem_data;
        w_rt_val = rt_data;
        if (rt_idx != '0 && fwd_ex_valid && fwd_ex_idx == rt_idx)
            w_rt_val = fwd_ex_data;
        else if (rt_idx != '0 && fwd_mem_valid && fwd_mem_idx == rt_idx)
            w_rt_val = fwd_mem_data;
    end
    logic w_unused;
    assign w_unused = shamt_in[4];
`else
    assign w_rs_val = rs_data;
    assign w_rt_val = rt_data;
    logic w_unused;
    assign w_unused = ^{fwd_ex_valid, fwd_mem_valid, fwd_ex_idx,
                        fwd_mem_idx, fwd_ex_data, fwd_mem_data,
                        shamt_in[4]};
`endif

    always_comb begin
        w_b = w_rt_val;
        unique case (w_bsel)
            B_RT:   w_b = w_rt_val;
            B_RS:   w_b = w_rs_val;
            B_SEXT: w_b = {{(DATA_W-16){imm16[15]}}, imm16};
            B_ZEXT: w_b = {{(DATA_W-16){1'b0}}, imm16};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid  <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= 4'b0000;
            r_cn     <= 1'b0;
            r_shamt  <= 4'b0000;
            r_wb_idx <= '0;
            r_wb_en  <= 1'b0;
            r_ill    <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
            r_wb_en <= 1'b0;
            r_op    <= 4'b0000;
            r_cn    <= 1'b0;
        end else if (w_load) begin
            r_valid  <= 1'b1;
            r_a      <= w_rs_val;
            r_b      <= w_b;
            r_op     <= w_op;
            r_cn     <= (w_op == 4'b0010);
            r_shamt  <= shamt_in[3:0];
            r_wb_idx <= w_wb_idx;
            r_wb_en  <= w_wb_en;
            r_ill    <= w_ill;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid = r_valid;
    assign alu_a     = r_a;
    assign alu_b     = r_b;
    assign alu_op    = r_op;
    assign alu_cn    = r_cn;
    assign alu_shamt = r_shamt;
    assign wb_idx    = r_wb_idx;
    assign wb_en     = r_wb_en;
    assign illegal   = r_ill;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage.
// Forwarding expectations follow FORWARDING_EN.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs_idx, rt_idx, rd_idx;
    logic [31:0] rs_data, rt_data;
    logic [15:0] imm16;
    logic [4:0]  shamt_in;
    logic        flush;
    logic        fwd_ex_valid, fwd_mem_valid;
    logic [4:0]  fwd_ex_idx, fwd_mem_idx;
    logic [31:0] fwd_ex_data, fwd_mem_data;
    logic        out_valid, out_ready;
    logic [31:0] alu_a, alu_b;
    logic [3:0]  alu_op;
    logic        alu_cn;
    logic [3:0]  alu_shamt;
    logic [4:0]  wb_idx;
    logic        wb_en, illegal;

    int checks = 0;
    int errors = 0;

    alu_issue_stage #(.DATA_W(32), .REG_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct(funct),
        .rs_idx(rs_idx), .rt_idx(rt_idx), .rd_idx(rd_idx),
        .rs_data(rs_data), .rt_data(rt_data),
        .imm16(imm16), .shamt_in(shamt_in), .flush(flush),
        .fwd_ex_valid(fwd_ex_valid), .fwd_mem_valid(fwd_mem_valid),
        .fwd_ex_idx(fwd_ex_idx), .fwd_mem_idx(fwd_mem_idx),
        .fwd_ex_data(fwd_ex_data), .fwd_mem_data(fwd_mem_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_cn(alu_cn), .alu_shamt(alu_shamt),
        .wb_idx(wb_idx), .wb_en(wb_en), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_r(input logic [5:0] f, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd,
                         input logic [31:0] a, input logic [31:0] b);
        opcode = 6'b000000; funct = f;
        rs_idx = rs; rt_idx = rt; rd_idx = rd;
        rs_data = a; rt_data = b;
    endtask

    task automatic set_i(input logic [5:0] op, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [31:0] a,
                         input logic [31:0] b, input logic [15:0] imm);
        opcode = op; funct = 6'b000000;
        rs_idx = rs; rt_idx = rt; rd_idx = 5'd0;
        rs_data = a; rt_data = b; imm16 = imm;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
        opcode = '0; funct = '0; rs_idx = '0; rt_idx = '0; rd_idx = '0;
        rs_data = '0; rt_data = '0; imm16 = '0; shamt_in = '0;
        fwd_ex_valid = 1'b0; fwd_mem_valid = 1'b0;
        fwd_ex_idx = '0; fwd_mem_idx = '0;
        fwd_ex_data = '0; fwd_mem_data = '0;
        #2;
        chk("rst_valid", out_valid, 0);
        chk("rst_op", alu_op, 0);
        chk("rst_ready", in_ready, 1);
        #1 rst_n = 1'b1;

        // add
        set_r(6'b100000, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7);
        in_valid = 1'b1;
        tick();
        chk("add_valid", out_valid, 1);
        chk("add_op", alu_op, 4'b0001);
        chk("add_a", alu_a, 32'd5);
        chk("add_b", alu_b, 32'd7);
        chk("add_wbidx", wb_idx, 5'd3);
        chk("add_wben", wb_en, 1);
        chk("add_cn", alu_cn, 0);
        chk("add_ill", illegal, 0);

        // addi sign-extends, andi zero-extends
        set_i(6'b001000, 5'd1, 5'd9, 32'd10, 32'd0, 16'hFFFE);
        tick();
        chk("addi_b", alu_b, 32'hFFFFFFFE);
        chk("addi_a", alu_a, 32'd10);
        chk("addi_op", alu_op, 4'b0001);
        chk("addi_wbidx", wb_idx, 5'd9);
        chk("addi_wben", wb_en, 1);
        set_i(6'b001100, 5'd1, 5'd9, 32'd10, 32'd0, 16'hFFFE);
        tick();
        chk("andi_b", alu_b, 32'h0000FFFE);
        chk("andi_op", alu_op, 4'b0101);

        // sub: carry-in set, shamt bit 4 dropped
        set_r(6'b100010, 5'd1, 5'd2, 5'd4, 32'd9, 32'd3);
        shamt_in = 5'b10110;
        tick();
        chk("sub_op", alu_op, 4'b0010);
        chk("sub_cn", alu_cn, 1);
        chk("sub_shamt", alu_shamt, 4'b0110);

        // backpressure
        set_r(6'b100101, 5'd1, 5'd2, 5'd6, 32'h11, 32'h22);
        tick();
        chk("or_op", alu_op, 4'b0110);
        out_ready = 1'b0;
        set_r(6'b100110, 5'd1, 5'd2, 5'd8, 32'h33, 32'h44);
        #1;
        chk("bp_ready", in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_valid", out_valid, 1);
            chk("bp_op", alu_op, 4'b0110);
            chk("bp_a", alu_a, 32'h11);
            chk("bp_ready_hold", in_ready, 0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", in_ready, 1);
        tick();
        chk("xor_op", alu_op, 4'b1000);
        chk("xor_a", alu_a, 32'h33);
        chk("xor_wbidx", wb_idx, 5'd8);

        // drain: valid drops, data holds
        in_valid = 1'b0;
        tick();
        chk("drain_valid", out_valid, 0);
        chk("drain_op", alu_op, 4'b1000);
        chk("drain_a", alu_a, 32'h33);

        // jr
        in_valid = 1'b1;
        set_r(6'b001000, 5'd1, 5'd2, 5'd5, 32'h40, 32'h99);
        tick();
        chk("jr_op", alu_op, 4'b1011);
        chk("jr_b", alu_b, 32'h40);
        chk("jr_wben", wb_en, 0);

        // flush over held instruction and incoming one
        set_r(6'b100111, 5'd1, 5'd2, 5'd7, 32'h1, 32'h2);
        tick();
        chk("nor_op", alu_op, 4'b0111);
        out_ready = 1'b0;
        flush = 1'b1;
        set_r(6'b100000, 5'd1, 5'd2, 5'd9, 32'h5, 32'h6);
        #1;
        chk("flush_ready", in_ready, 0);
        tick();
        chk("flush_valid", out_valid, 0);
        chk("flush_wben", wb_en, 0);
        chk("flush_op", alu_op, 0);
        flush = 1'b0;
        out_ready = 1'b1;

        // illegal funct and opcode
        set_r(6'b111111, 5'd1, 5'd2, 5'd9, 32'h5, 32'h6);
        tick();
        chk("illf_valid", out_valid, 1);
        chk("illf_ill", illegal, 1);
        chk("illf_op", alu_op, 0);
        chk("illf_wben", wb_en, 0);
        set_i(6'b111111, 5'd1, 5'd2, 32'h5, 32'h6, 16'h0);
        tick();
        chk("illo_ill", illegal, 1);
        chk("illo_valid", out_valid, 1);

        // destination 0 never written
        set_r(6'b100000, 5'd1, 5'd2, 5'd0, 32'h5, 32'h6);
        tick();
        chk("rd0_wben", wb_en, 0);
        chk("rd0_ill", illegal, 0);

        // sw and beq
        set_i(6'b101011, 5'd1, 5'd2, 32'h100, 32'h77, 16'h0004);
        tick();
        chk("sw_op", alu_op, 4'b0001);
        chk("sw_b", alu_b, 32'h4);
        chk("sw_wben", wb_en, 0);
        set_i(6'b000100, 5'd1, 5'd2, 32'h100, 32'h77, 16'h0004);
        tick();
        chk("beq_op", alu_op, 4'b0010);
        chk("beq_b", alu_b, 32'h77);
        chk("beq_cn", alu_cn, 1);
        chk("beq_wben", wb_en, 0);

        // forwarding
        fwd_ex_idx = 5'd4; fwd_ex_data = 32'hAA; fwd_ex_valid = 1'b1;
        fwd_mem_idx = 5'd4; fwd_mem_data = 32'hBB; fwd_mem_valid = 1'b1;
        set_r(6'b100000, 5'd4, 5'd2, 5'd3, 32'h11, 32'h22);
        tick();
`ifdef FORWARDING_EN
        chk("fwd_ex_a", alu_a, 32'hAA);
`else
        chk("fwd_ex_a", alu_a, 32'h11);
`endif
        fwd_ex_valid = 1'b0;
        tick();
`ifdef FORWARDING_EN
        chk("fwd_mem_a", alu_a, 32'hBB);
`else
        chk("fwd_mem_a", alu_a, 32'h11);
`endif
        fwd_ex_valid = 1'b1;
        fwd_ex_idx = 5'd0; fwd_mem_idx = 5'd0;
        set_r(6'b100000, 5'd0, 5'd2, 5'd3, 32'h55, 32'h22);
        tick();
        chk("fwd_zero_a", alu_a, 32'h55);
        fwd_ex_idx = 5'd4;
        set_i(6'b001000, 5'd1, 5'd4, 32'h1, 32'h2, 16'h0010);
        tick();
        chk("fwd_imm_b", alu_b, 32'h10);
        fwd_ex_valid = 1'b0; fwd_mem_valid = 1'b0;

        // async reset mid-cycle while holding a valid instruction
        set_r(6'b100000, 5'd1, 5'd2, 5'd3, 32'h5, 32'h7);
        tick();
        chk("prerst_valid", out_valid, 1);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_a", alu_a, 0);
        chk("arst_b", alu_b, 0);
        chk("arst_op", alu_op, 0);
        chk("arst_wbidx", wb_idx, 0);
        chk("arst_wben", wb_en, 0);
        chk("arst_ready", in_ready, 1);
        rst_n = 1'b1;
        tick();
        chk("post_valid", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- ID/EX pipeline stage directly upstream of the 32-bit ALU.
- Decodes MIPS-style opcode/funct into the 4-bit ALU operation code and selects/extends operands.
- Optionally forwards results from later stages.
- Registers everything behind a valid/ready handshake, so the ALU sees stable a, b, ALUop, cn and shamt for one full cycle per instruction.

Parameters:
- DATA_W, 32, operand/result width (ALU fixed at 32).
- REG_W, 5, register-index width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  decode stage presents an instruction.
- in_ready  out  1  stage can accept this cycle.
- opcode  in  6  instruction [31:26].
- funct  in  6  instruction [5:0].
- rs_idx, rt_idx, rd_idx  in  REG_W  source/dest indices.
- rs_data, rt_data  in  DATA_W  register-file read data.
- imm16  in  16  immediate.
- shamt_in  in  5  instruction [10:6].
- flush  in  1  kill held and incoming instruction.
- fwd_ex_valid, fwd_mem_valid  in  1  forwarding source writes a register.
- fwd_ex_idx, fwd_mem_idx  in  REG_W  forwarded destination index.
- fwd_ex_data, fwd_mem_data  in  DATA_W  forwarded value.
- out_valid  out  1  ALU inputs valid.
- out_ready  in  1  downstream consumes this cycle.
- alu_a, alu_b  out  DATA_W  ALU operands.
- alu_op  out  4  ALU operation code.
- alu_cn  out  1  carry-in.
- alu_shamt  out  4  shift amount.
- wb_idx  out  REG_W  destination register.
- wb_en  out  1  instruction writes a register.
- illegal  out  1  undecodable instruction.

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset: out_valid=0, alu_a=0, alu_b=0, alu_op=4'b0000, alu_cn=0, alu_shamt=0, wb_idx=0, wb_en=0, illegal=0. Reset asserted mid-transfer drops the held instruction immediately.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Load when in_valid && in_ready.
  - If out_valid && !out_ready, all outputs hold.
  - If out_ready with no new input, out_valid drops to 0 and other outputs hold their values.
- Latency: exactly 1 cycle from accept to out_valid.
- flush: on the next edge out_valid=0, wb_en=0, alu_op=0000, and the incoming instruction is discarded. flush has priority over load. in_ready is unaffected.
- R-type decode (opcode 000000), funct -> alu_op:
  - 100000/100001 -> 0001 (add)
  - 100010/100011 -> 0010 (sub)
  - 011000 -> 0011 (mult)
  - 011010 -> 0100 (div)
  - 100100 -> 0101 (and)
  - 100101 -> 0110 (or)
  - 100111 -> 0111 (nor)
  - 100110 -> 1000 (xor)
  - 101000 -> 1001 (not)
  - 101001 -> 1010 (nand)
  - 001000 -> 1011 (jr)
  - R-type operands: a=rs, b=rt, except jr: b=rs.
  - wb_idx=rd; wb_en=1 except jr.
- I-type decode:
  - addi 001000, addiu 001001, lw 100011, sw 101011 -> 0001, b=sign-extended imm16.
  - andi 001100 -> 0101, ori 001101 -> 0110, xori 001110 -> 1000, b=zero-extended imm16.
  - beq 000100 -> 0010, b=rt, wb_en=0.
  - sw: wb_en=0.
  - Other I-type: wb_idx=rt, wb_en=1.
- Any other opcode/funct: alu_op=0000, wb_en=0, illegal=1, out_valid still asserted.
- alu_cn=1 for op 0010, else 0.
- alu_shamt=shamt_in[3:0]; bit 4 is dropped.
- wb_en forced 0 when destination index is 0.

Optional Feature:
- Macro FORWARDING_EN.
- Defined: each register-sourced operand (rs, and rt when used) is replaced at load time by fwd_ex_data if fwd_ex_valid && fwd_ex_idx==src, else by fwd_mem_data on the equivalent mem match, else by the register-file value.
  - EX has priority over MEM.
  - Index 0 is never forwarded.
  - Immediate operands are never forwarded.
- Undefined: fwd_* ports exist but are ignored; operands come only from rs_data/rt_data.

Test Plan:
- Reset: rst_n low asynchronously mid-cycle with out_valid=1 -> all outputs zero immediately, in_ready=1.
- add: opcode 0, funct 100000, rs_data=5, rt_data=7, rd=3 -> next cycle out_valid=1, alu_op=0001, a=5, b=7, wb_idx=3, wb_en=1, cn=0.
- addi: opcode 001000, imm16=16'hFFFE, rs_data=10 -> b=32'hFFFFFFFE, alu_op=0001. Same imm with andi -> b=32'h0000FFFE, alu_op=0101.
- Backpressure: out_ready=0 for 3 cycles after load -> in_ready=0, outputs stable. out_ready=1 with new in_valid -> next instruction loaded the same cycle.
- flush with in_valid=1 and held instruction -> out_valid=0, wb_en=0 next cycle. Illegal funct 111111 -> out_valid=1, illegal=1, alu_op=0000.
- FORWARDING_EN: rs_idx=4, fwd_ex_idx=4 (data 0xAA), fwd_mem_idx=4 (data 0xBB), both valid -> a=0xAA. Only mem valid -> a=0xBB. rs_idx=0 with match -> a=rs_data.
